// File: rtl/twos_comp_sequencer.sv
// Bit-serial two's complement negator: captures one word, emits the result LSB first, then holds it.
// Latency: out_valid rises WIDTH edges after the accept edge; one word per WIDTH+2 cycles at best.
// Backpressure: result held in HOLD until out_ready; in_ready only in IDLE, requests while busy are dropped.
module twos_comp_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             t_clock,
  input  logic             r,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy,
  output logic             ser_bit
);

  // Counter wide enough to index bits 0..WIDTH-1.
  localparam int               CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST_IDX = CW'(WIDTH - 1);
  // Most-negative value: the one operand whose negation does not fit.
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opnd_q,  opnd_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             neg_q,   neg_d;
  logic             ovf_q,   ovf_d;
  logic             seen_q,  seen_d;

  logic             accept;
  logic             last_bit;
  logic             cur_bit;
  logic             ser_w;

  // A word is taken only from IDLE; anything offered while busy is simply not captured.
  assign accept   = (state_q == ST_IDLE) && in_valid;
  assign last_bit = (cnt_q == LAST_IDX);
  assign cur_bit  = opnd_q[cnt_q];
  // Serial negation: copy bits up to and including the first 1, invert everything above it.
  assign ser_w    = cur_bit ^ (neg_q & seen_q);

  // State register; reset wins over every other input.
  always_ff @(posedge t_clock) begin
    if (r) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode; everything except ser_bit comes straight from registers.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    out_valid = (state_q == ST_HOLD);
    out_ovf   = (state_q == ST_HOLD) && ovf_q;
    out_data  = res_q;
    ser_bit   = (state_q == ST_SHIFT) ? ser_w : 1'b0;
  end

  // Datapath next-state: capture on accept, one result bit per SHIFT cycle, hold otherwise.
  always_comb begin
    opnd_d = opnd_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    neg_d  = neg_q;
    ovf_d  = ovf_q;
    seen_d = seen_q;
    if (accept) begin
      opnd_d = in_data;
      neg_d  = in_neg;
      ovf_d  = in_neg && (in_data == MOST_NEG);
      cnt_d  = '0;
      seen_d = 1'b0;
      res_d  = '0;
    end else if (state_q == ST_SHIFT) begin
      res_d[cnt_q] = ser_w;
      seen_d       = seen_q | cur_bit;
      if (!last_bit) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Datapath registers; reset clears the visible result so no stale word leaks out.
  always_ff @(posedge t_clock) begin
    if (r) begin
      opnd_q <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      opnd_q <= opnd_d;
      res_q  <= res_d;
      cnt_q  <= cnt_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
      seen_q <= seen_d;
    end
  end

endmodule

// File: tb/tb_twos_comp_sequencer.sv
// Bench for twos_comp_sequencer at WIDTH=8: directed words with literal expectations
// plus a per-cycle comparison against an arithmetic reference model.
module tb_twos_comp_sequencer;

  localparam int W = 8;

  logic         t_clock = 1'b0;
  logic         r;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_neg;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_ovf;
  logic         busy;
  logic         ser_bit;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  twos_comp_sequencer #(.WIDTH(W)) dut (
    .t_clock  (t_clock),
    .r        (r),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_neg   (in_neg),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .busy     (busy),
    .ser_bit  (ser_bit)
  );

  always #5 t_clock = ~t_clock;

  always @(posedge t_clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: phase -1 = idle, 0..W-1 = serialising that bit, W = holding the result.
  // The result itself is plain arithmetic negation; overflow is the most-negative operand.
  int           m_ph  = -1;
  logic [W-1:0] m_res = '0;
  logic         m_ovf = 1'b0;
  bit           live  = 1'b0;

  always @(posedge t_clock) begin
    if (r) begin
      m_ph = -1;
      live = 1'b1;
    end else if (live) begin
      if (m_ph == -1) begin
        if (in_valid) begin
          m_res = in_neg ? (8'd0 - in_data) : in_data;
          m_ovf = in_neg && (in_data == 8'h80);
          m_ph  = 0;
        end
      end else if (m_ph < W) begin
        m_ph = m_ph + 1;
      end else if (out_ready) begin
        m_ph = -1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge t_clock) begin
    if (live) begin
      check("m_in_ready",  in_ready,  (m_ph == -1));
      check("m_busy",      busy,      (m_ph != -1));
      check("m_out_valid", out_valid, (m_ph == W));
      check("m_out_ovf",   out_ovf,   (m_ph == W) && m_ovf);
      check("m_ser_bit",   ser_bit,   (m_ph >= 0 && m_ph < W) ? m_res[m_ph] : 1'b0);
      if (m_ph == W) check("m_out_data", out_data, m_res);
    end
  end

  // Observers on the DUT itself: accept instants (busy rising) and delivered results.
  int           acc_q[$];
  logic [W-1:0] got_q[$];
  logic         prev_busy = 1'b0;

  always @(negedge t_clock) begin
    if (live && busy === 1'b1 && prev_busy !== 1'b1) acc_q.push_back(cyc);
    prev_busy = busy;
  end

  always @(posedge t_clock) begin
    if (live && out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back(out_data);
  end

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge t_clock);
      n++;
    end
    check("ready_wait", in_ready, 1'b1);
  endtask

  // Offer one word from IDLE, collect its serial bits, then optionally stall in HOLD.
  task automatic run_word(input logic [W-1:0] d, input logic n,
                          input logic [W-1:0] exp_d, input logic exp_o, input int stall);
    logic [W-1:0] s;
    int lat;
    wait_ready();
    in_valid  = 1'b1;
    in_data   = d;
    in_neg    = n;
    out_ready = (stall == 0);
    @(negedge t_clock);
    in_valid = 1'b0;
    check("accept_busy", busy, 1'b1);
    s   = '0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (lat < W) s[lat] = ser_bit;
      @(negedge t_clock);
      lat++;
    end
    check("latency",  lat,      W);
    check("ser_bits", s,        exp_d);
    check("out_data", out_data, exp_d);
    check("out_ovf",  out_ovf,  exp_o);
    for (int k = 0; k < stall; k++) begin
      in_valid = (k % 2 == 1);
      in_data  = 8'hA5;
      @(negedge t_clock);
      check("stall_valid", out_valid, 1'b1);
      check("stall_data",  out_data,  exp_d);
      check("stall_busy",  busy,      1'b1);
      check("stall_rdy",   in_ready,  1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge t_clock);
    out_ready = 1'b0;
    check("release_valid", out_valid, 1'b0);
    check("release_ready", in_ready,  1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n;
    int hits;
    r         = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_neg    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge t_clock);
    r = 1'b0;
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_busy",      busy,      1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_ovf",   out_ovf,   1'b0);
    check("rst_ser_bit",   ser_bit,   1'b0);
    check("rst_out_data",  out_data,  8'h00);

    run_word(8'h05, 1'b1, 8'hFB, 1'b0, 0);
    run_word(8'h80, 1'b1, 8'h80, 1'b1, 0);
    run_word(8'h00, 1'b1, 8'h00, 1'b0, 0);
    run_word(8'h3C, 1'b0, 8'h3C, 1'b0, 0);
    run_word(8'hFF, 1'b0, 8'hFF, 1'b0, 0);

    // Stall in HOLD for five cycles with dropped requests; nothing may be queued afterwards.
    run_word(8'h7F, 1'b1, 8'h81, 1'b0, 5);
    hits = 0;
    repeat (3) begin
      @(negedge t_clock);
      if (busy !== 1'b0) hits++;
    end
    check("no_queued_word", hits, 0);

    // Reset on the fourth SHIFT cycle of 0x5A abandons the word.
    wait_ready();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    in_neg   = 1'b0;
    @(negedge t_clock);
    in_valid = 1'b0;
    repeat (3) @(negedge t_clock);
    r = 1'b1;
    @(negedge t_clock);
    r = 1'b0;
    check("mid_rst_ready",    in_ready,  1'b1);
    check("mid_rst_busy",     busy,      1'b0);
    check("mid_rst_valid",    out_valid, 1'b0);
    check("mid_rst_data",     out_data,  8'h00);
    hits = 0;
    repeat (12) begin
      @(negedge t_clock);
      if (out_valid !== 1'b0) hits++;
    end
    check("abandoned_no_valid", hits, 0);

    // Back-to-back with in_valid held: accepts exactly W+2 edges apart.
    wait_ready();
    acc_q.delete();
    got_q.delete();
    in_valid  = 1'b1;
    in_data   = 8'h01;
    in_neg    = 1'b1;
    out_ready = 1'b1;
    @(negedge t_clock);
    in_data = 8'hFF;
    n = 0;
    while (acc_q.size() < 2 && n < 30) begin
      @(negedge t_clock);
      n++;
    end
    in_valid = 1'b0;
    check("b2b_accepts", acc_q.size(), 2);
    n = 0;
    while (got_q.size() < 2 && n < 30) begin
      @(negedge t_clock);
      n++;
    end
    check("b2b_results", got_q.size(), 2);
    if (acc_q.size() >= 2) check("b2b_spacing", acc_q[1] - acc_q[0], 10);
    if (got_q.size() >= 2) begin
      check("b2b_first",  got_q[0], 8'hFF);
      check("b2b_second", got_q[1], 8'h01);
    end
    out_ready = 1'b0;
    repeat (3) @(negedge t_clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
